cfg_cmd_ctrl: RTL



---
 rtl/cfg_cmd_pkg.sv | 26 ++
 rtl/cfg_vsync_edge.sv | 26 ++
 rtl/cfg_cmd_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cfg_cmd_pkg.sv
// Shared encodings for the SPI configuration controller: FSM states, framing
// bytes, command codes and the saturating error-count helper.
package cfg_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_CMD  = 3'd1,
    GET_DATA = 3'd2,
    GET_CSUM = 3'd3,
    EXEC     = 3'd4
  } state_t;

  localparam logic [7:0] HDR      = 8'h55;
  localparam logic [7:0] ACK      = 8'hA5;
  localparam logic [7:0] NACK     = 8'h5E;

  localparam logic [7:0] CMD_THR  = 8'h01;
  localparam logic [7:0] CMD_CH   = 8'h02;
  localparam logic [7:0] CMD_TGL  = 8'h03;
  localparam logic [7:0] CMD_STAT = 8'h10;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cfg_vsync_edge.sv
// Brings the camera vsync into the sclk domain and flags its rising edge.
module cfg_vsync_edge (
  input  logic sclk,
  input  logic s_rst,
  input  logic vsync,
  output logic rise
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= vsync;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Combinational pulse: the commit register downstream is the third stage.
  assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/cfg_cmd_ctrl.sv
// SPI command parser with shadow registers; threshold and channel select are
// committed together on each synchronised vsync rising edge.
module cfg_cmd_ctrl
  import cfg_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] THR_DEF     = 8'd50,
  parameter logic [7:0] THR_MIN     = 8'd10,
  parameter logic [7:0] THR_MAX     = 8'd200
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [7:0] rxd_data,
  input  logic       rxd_flag,
  input  logic       vsync,
  output logic [7:0] yuzhi,
  output logic       ch_select,
  output logic [7:0] txd_data,
  output logic       txd_load,
  output logic       pend,
  output logic [7:0] err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      cmd_r, data_r, csum_r;
  logic [7:0]      shd_thr, shd_thr_nxt;
  logic            shd_ch, shd_ch_nxt;
  logic [7:0]      yuzhi_nxt;
  logic            ch_nxt;
  logic [7:0]      resp, sum;
  logic            rsp_vld, reject, in_get, timeout, rise;

  cfg_vsync_edge u_vsync_edge (
    .sclk  (sclk),
    .s_rst (s_rst),
    .vsync (vsync),
    .rise  (rise)
  );

  assign in_get  = (state == GET_CMD) || (state == GET_DATA) || (state == GET_CSUM);
  assign timeout = in_get && !rxd_flag && (to_cnt == TO_W'(TIMEOUT_CYC));
  assign sum     = cmd_r + data_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rxd_flag && rxd_data == HDR) state_nxt = GET_CMD;
      GET_CMD:  if (rxd_flag) state_nxt = GET_DATA; else if (timeout) state_nxt = IDLE;
      GET_DATA: if (rxd_flag) state_nxt = GET_CSUM; else if (timeout) state_nxt = IDLE;
      GET_CSUM: if (rxd_flag) state_nxt = EXEC;     else if (timeout) state_nxt = IDLE;
      EXEC:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Command execution; status reads the registered pend/ch_select.
  always_comb begin
    shd_thr_nxt = shd_thr;
    shd_ch_nxt  = shd_ch;
    resp        = NACK;
    rsp_vld     = 1'b0;
    reject      = timeout;
    if (state == EXEC) begin
      rsp_vld = 1'b1;
      if (sum != csum_r) begin
        reject = 1'b1;
      end else begin
        case (cmd_r)
          CMD_THR: begin
            if (data_r >= THR_MIN && data_r <= THR_MAX) begin
              shd_thr_nxt = data_r;
              resp        = ACK;
            end else begin
              reject = 1'b1;
            end
          end
          CMD_CH: begin
            shd_ch_nxt = data_r[0];
            resp       = ACK;
          end
          CMD_TGL: begin
            shd_ch_nxt = ~shd_ch;
            resp       = ACK;
          end
          CMD_STAT: resp = {pend, ch_select, 6'b0};
          default:  reject = 1'b1;
        endcase
      end
    end
  end

  // Commit samples the shadow before any same-cycle write lands.
  assign yuzhi_nxt = rise ? shd_thr : yuzhi;
  assign ch_nxt    = rise ? shd_ch  : ch_select;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state     <= IDLE;
      to_cnt    <= '0;
      shd_thr   <= THR_DEF;
      shd_ch    <= 1'b0;
      yuzhi     <= THR_DEF;
      ch_select <= 1'b0;
      txd_data  <= 8'h00;
      txd_load  <= 1'b0;
      pend      <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      state     <= state_nxt;
      to_cnt    <= (rxd_flag || !in_get || timeout) ? '0 : to_cnt + TO_W'(1);
      shd_thr   <= shd_thr_nxt;
      shd_ch    <= shd_ch_nxt;
      yuzhi     <= yuzhi_nxt;
      ch_select <= ch_nxt;
      txd_load  <= rsp_vld;
      if (rsp_vld) txd_data <= resp;
      pend      <= (shd_thr_nxt != yuzhi_nxt) || (shd_ch_nxt != ch_nxt);
      if (reject) err_cnt <= sat_inc(err_cnt);
    end
  end

  always_ff @(posedge sclk) begin
    if (rxd_flag && state == GET_CMD)  cmd_r  <= rxd_data;
    if (rxd_flag && state == GET_DATA) data_r <= rxd_data;
    if (rxd_flag && state == GET_CSUM) csum_r <= rxd_data;
  end

endmodule
